reset_sequencer: RTL

//   Generates and sequences reset: holds a set of downstream active-low resets asserted,

---
 rtl/reset_seq_pkg.sv | 14 +
 rtl/reset_sequencer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the top-of-tree reset sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        RS_IDLE,
        RS_ASSERT,
        RS_RELEASE
    } rs_state_t;

    function automatic int rs_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_sequencer.sv
// Holds a set of active-low downstream resets low, then releases them one stage at a time.
// A full sequence runs after block reset and on every soft request.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES    = 3,
    parameter int ASSERT_CYCLES = 16,
    parameter int STAGE_DELAY   = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req,
    input  logic                  hold,
    output logic [NUM_STAGES-1:0] stage_reset_n,
    output logic                  busy,
    output logic                  ack
);

    localparam int CNT_W = $clog2(rs_max(ASSERT_CYCLES, STAGE_DELAY)) + 1;
    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CNT_W-1:0]      ASSERT_LAST = CNT_W'(ASSERT_CYCLES - 1);
    localparam logic [CNT_W-1:0]      DELAY_LAST  = CNT_W'(STAGE_DELAY - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST    = IDX_W'(NUM_STAGES - 1);
    localparam logic [NUM_STAGES-1:0] STAGE_ONE   = NUM_STAGES'(1);

    if (NUM_STAGES < 1) begin : g_bad_num_stages
        $error("reset_sequencer: NUM_STAGES must be >= 1");
    end
    if (ASSERT_CYCLES < 1) begin : g_bad_assert_cycles
        $error("reset_sequencer: ASSERT_CYCLES must be >= 1");
    end
    if (STAGE_DELAY < 1) begin : g_bad_stage_delay
        $error("reset_sequencer: STAGE_DELAY must be >= 1");
    end

    rs_state_t               state, state_nx;
    logic [CNT_W-1:0]        cnt, cnt_nx;
    logic [IDX_W-1:0]        idx, idx_nx;
    logic [NUM_STAGES-1:0]   stage_nx;
    logic                    busy_nx;
    logic                    ack_nx;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= RS_ASSERT;
            cnt           <= '0;
            idx           <= '0;
            stage_reset_n <= '0;
            busy          <= 1'b1;
            ack           <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            idx           <= idx_nx;
            stage_reset_n <= stage_nx;
            busy          <= busy_nx;
            ack           <= ack_nx;
        end
    end

    // One counter serves both the assert window and the per-stage spacing.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        stage_nx = stage_reset_n;
        busy_nx  = busy;
        ack_nx   = 1'b0;

        unique case (state)
            RS_IDLE: begin
                stage_nx = '1;
                busy_nx  = 1'b0;
                if (req) begin
                    state_nx = RS_ASSERT;
                    cnt_nx   = '0;
                    stage_nx = '0;
                    busy_nx  = 1'b1;
                end
            end

            RS_ASSERT: begin
                stage_nx = '0;
                busy_nx  = 1'b1;
                if (req) begin
                    cnt_nx = '0;
                end else if (cnt == ASSERT_LAST) begin
                    if (!hold) begin
                        state_nx = RS_RELEASE;
                        cnt_nx   = '0;
                        idx_nx   = '0;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end

            RS_RELEASE: begin
                busy_nx = 1'b1;
                if (req) begin
                    state_nx = RS_ASSERT;
                    cnt_nx   = '0;
                    stage_nx = '0;
                end else if (cnt == DELAY_LAST) begin
                    stage_nx = stage_reset_n | (STAGE_ONE << idx);
                    cnt_nx   = '0;
                    if (idx == IDX_LAST) begin
                        state_nx = RS_IDLE;
                        busy_nx  = 1'b0;
                        ack_nx   = 1'b1;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end

            default: begin
                state_nx = RS_ASSERT;
                cnt_nx   = '0;
                idx_nx   = '0;
                stage_nx = '0;
                busy_nx  = 1'b1;
            end
        endcase
    end

endmodule
